// File: rtl/debouncer_repeat.sv
// Multi-channel button conditioner: shared sample tick, per-channel hysteresis debounce,
// edge strobes and press-and-hold auto-repeat pulses.
module debouncer_repeat #(
    parameter int width            = 1,
    parameter int sample_count_max = 25000,
    parameter int pulse_count_max  = 150,
    parameter int hold_samples     = 2000,
    parameter int repeat_samples   = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] glitchy_signal,
    input  logic [width-1:0] repeat_en,
    output logic [width-1:0] debounced_signal,
    output logic [width-1:0] rising_pulse,
    output logic [width-1:0] falling_pulse,
    output logic [width-1:0] repeat_pulse
);

    localparam int SW   = (sample_count_max > 1) ? $clog2(sample_count_max) : 1;
    localparam int CW   = $clog2(pulse_count_max + 1);
    localparam int RMAX = (hold_samples > repeat_samples) ? hold_samples : repeat_samples;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(sample_count_max - 1);
    localparam logic [CW-1:0] CNT_MAX     = CW'(pulse_count_max);
    localparam logic [RW-1:0] HOLD_LAST   = RW'(hold_samples - 1);
    localparam logic [RW-1:0] REP_LAST    = RW'(repeat_samples - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rstate_t;

    logic [SW-1:0] sample_cnt_reg;
    logic          tick;

    assign tick = (sample_cnt_reg == SAMPLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_reg <= '0;
        end else if (tick) begin
            sample_cnt_reg <= '0;
        end else begin
            sample_cnt_reg <= sample_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < width; gi++) begin : g_ch
            logic [CW-1:0] cnt_reg, cnt_next;
            logic          deb_reg, deb_d1_reg, rising;
            rstate_t       state_reg, state_next;
            logic [RW-1:0] rcnt_reg, rcnt_next;
            logic          pulse;

            always_comb begin
                cnt_next = cnt_reg;
                if (tick) begin
                    if (glitchy_signal[gi] && cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + 1'b1;
                    end else if (!glitchy_signal[gi] && cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end

            // Level follows the updated count so it changes in the same edge as cnt.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg    <= '0;
                    deb_reg    <= 1'b0;
                    deb_d1_reg <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    deb_d1_reg <= deb_reg;
                    if (cnt_next == CNT_MAX) begin
                        deb_reg <= 1'b1;
                    end else if (cnt_next == '0) begin
                        deb_reg <= 1'b0;
                    end
                end
            end

            assign rising = deb_reg & ~deb_d1_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    rcnt_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    rcnt_reg  <= rcnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                rcnt_next  = rcnt_reg;
                pulse      = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (rising && repeat_en[gi]) begin
                            state_next = HOLD;
                            rcnt_next  = '0;
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            if (rcnt_reg == HOLD_LAST) begin
                                pulse      = 1'b1;
                                state_next = REPEAT;
                                rcnt_next  = '0;
                            end else begin
                                rcnt_next = rcnt_reg + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (tick) begin
                            if (rcnt_reg == REP_LAST) begin
                                pulse     = 1'b1;
                                rcnt_next = '0;
                            end else begin
                                rcnt_next = rcnt_reg + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        rcnt_next  = '0;
                    end
                endcase
                // Release or disable aborts, even on the cycle a pulse would fire.
                if (!deb_reg || !repeat_en[gi]) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                    pulse      = 1'b0;
                end
            end

            assign debounced_signal[gi] = deb_reg;
            assign rising_pulse[gi]     = rising;
            assign falling_pulse[gi]    = ~deb_reg & deb_d1_reg;
            assign repeat_pulse[gi]     = pulse;
        end
    endgenerate

endmodule

// File: tb/tb_debouncer_repeat.sv
// Self-checking bench for debouncer_repeat: directed button scenarios plus random bouncing
// inputs, all checked cycle by cycle against a tick-ordinal reference model.
module tb_debouncer_repeat;

    localparam int W   = 4;
    localparam int SCM = 4;
    localparam int P   = 3;
    localparam int H   = 4;
    localparam int R   = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] glitchy_signal = '0;
    logic [W-1:0] repeat_en = '0;
    logic [W-1:0] debounced_signal, rising_pulse, falling_pulse, repeat_pulse;

    debouncer_repeat #(
        .width(W), .sample_count_max(SCM), .pulse_count_max(P),
        .hold_samples(H), .repeat_samples(R)
    ) dut (
        .clk(clk), .rst_n(rst_n), .glitchy_signal(glitchy_signal), .repeat_en(repeat_en),
        .debounced_signal(debounced_signal), .rising_pulse(rising_pulse),
        .falling_pulse(falling_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: level counters, tick ordinals since the arming press.
    int m_cnt[W];
    bit m_deb[W], m_d1[W], m_arm[W];
    int m_pt[W];
    int m_sc, m_tt, cyc;
    int first_rise0, rise0_cnt, fall0_cnt, rep1_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < W; c++) begin
            m_cnt[c] = 0; m_deb[c] = 0; m_d1[c] = 0; m_arm[c] = 0; m_pt[c] = 0;
        end
        m_sc = 0; m_tt = 0; cyc = 0;
        first_rise0 = -1; rise0_cnt = 0; fall0_cnt = 0; rep1_cnt = 0;
    endtask

    // Called at a negedge: drive, check this cycle's outputs, advance model past the next posedge.
    task automatic step(input logic [W-1:0] g, input logic [W-1:0] e);
        bit tick;
        int k;
        logic [W-1:0] ed, er, ef, ep;
        glitchy_signal = g;
        repeat_en = e;
        #1;
        tick = (m_sc == SCM - 1);
        for (int c = 0; c < W; c++) begin
            ed[c] = m_deb[c];
            er[c] = m_deb[c] & ~m_d1[c];
            ef[c] = ~m_deb[c] & m_d1[c];
            ep[c] = 1'b0;
            if (tick && m_arm[c] && m_deb[c] && e[c]) begin
                k = m_tt - m_pt[c] + 1;
                ep[c] = (k == H) || (k > H && ((k - H) % R) == 0);
            end
        end
        check("debounced", 32'(debounced_signal), 32'(ed));
        check("rising", 32'(rising_pulse), 32'(er));
        check("falling", 32'(falling_pulse), 32'(ef));
        check("repeat", 32'(repeat_pulse), 32'(ep));
        if (rising_pulse[0]) begin
            rise0_cnt++;
            if (first_rise0 < 0) first_rise0 = cyc;
        end
        fall0_cnt += int'(falling_pulse[0]);
        rep1_cnt  += int'(repeat_pulse[1]);
        for (int c = 0; c < W; c++) begin
            if (!m_deb[c] || !e[c]) begin
                m_arm[c] = 0;
            end else if (!m_arm[c] && er[c]) begin
                m_arm[c] = 1;
                m_pt[c]  = m_tt + int'(tick);
            end
            if (tick) begin
                if (g[c] && m_cnt[c] < P) m_cnt[c]++;
                else if (!g[c] && m_cnt[c] > 0) m_cnt[c]--;
            end
            m_d1[c] = m_deb[c];
            if (m_cnt[c] == P) m_deb[c] = 1;
            else if (m_cnt[c] == 0) m_deb[c] = 0;
        end
        m_tt += int'(tick);
        m_sc = (m_sc + 1) % SCM;
        cyc++;
        @(negedge clk);
    endtask

    task automatic hold_ticks(input logic [W-1:0] g, input logic [W-1:0] e, input int n);
        for (int i = 0; i < n * SCM; i++) step(g, e);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {debounced_signal, rising_pulse, falling_pulse, repeat_pulse}, 32'h0);
    endtask

    // Hold reset with toggling inputs, then release at a negedge.
    task automatic reset_seq();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            glitchy_signal = W'($urandom);
            repeat_en = W'($urandom);
            @(posedge clk);
            #1;
            check_zero("in_reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    logic [W-1:0] target, g, e;

    initial begin
        model_reset();
        @(negedge clk);

        // Reset, then idle inputs: nothing moves.
        reset_seq();
        for (int i = 0; i < 100; i++) step('0, '0);

        // Press from release: rise at clk 12.
        reset_seq();
        for (int i = 0; i < 20; i++) step(4'b0001, '0);
        check("rise_cycle", 32'(first_rise0), 32'd12);

        // Pressed: short dropout keeps level.
        fall0_cnt = 0;
        hold_ticks(4'b0000, '0, 2);
        hold_ticks(4'b0001, '0, 3);
        check("dropout_no_fall", 32'(fall0_cnt), 32'd0);

        // Release: exactly one falling strobe.
        hold_ticks(4'b0000, '0, 4);
        check("release_fall", 32'(fall0_cnt), 32'd1);

        // Single-tick glitch from released state.
        rise0_cnt = 0;
        hold_ticks(4'b0001, '0, 1);
        hold_ticks(4'b0000, '0, 3);
        check("glitch_no_rise", 32'(rise0_cnt), 32'd0);

        // Repeat on ch1: pulses at tick ordinals 4,6,...,20 while level stays high.
        rep1_cnt = 0;
        hold_ticks(4'b0010, 4'b0010, 20);
        hold_ticks(4'b0000, 4'b0010, 10);
        check("repeat_count", 32'(rep1_cnt), 32'd9);

        rep1_cnt = 0;
        hold_ticks(4'b0010, 4'b0000, 20);
        hold_ticks(4'b0000, 4'b0000, 10);
        check("repeat_disabled", 32'(rep1_cnt), 32'd0);

        // Staggered presses, then async reset mid-HOLD.
        for (int c = 0; c < W; c++) hold_ticks(W'((1 << (c + 1)) - 1), '1, 2);
        hold_ticks('1, '1, 2);
        check("multi_pressed", 32'(debounced_signal), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) step('0, '1);

        // Random bouncing presses with slowly varying targets and enables.
        target = '0;
        e = '1;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(59) == 0) target[c] = ~target[c];
                if ($urandom_range(199) == 0) e[c] = ~e[c];
                g[c] = target[c] ^ ($urandom_range(9) == 0);
            end
            if (i == 2000) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_zero("rand_async_reset");
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end
            step(g, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
